lcd_result_formatter: RTL and testbench

- Sits between the ALU and the LCD driver: converts a signed 16-bit ALU result into a 7-byte LCD stream (one DDRAM address command, then a sign character, then 5 decimal digit characters).
- A serial double-dabble stage does the binary-to-BCD conversion.
- Characters are emitted one per valid/ready transfer to the driver, so the CPU no longer has to sequence individual LCD characters.

---
 rtl/lcd_result_formatter_pkg.sv | 38 +++
 rtl/lcd_result_formatter_if.sv | 24 ++
 rtl/lcd_result_formatter_bin2bcd.sv | 51 +++++
 rtl/lcd_result_formatter.sv | 144 ++++++++++++++
 tb/tb_lcd_result_formatter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_result_formatter_pkg.sv
// Shared types, ASCII constants and small helpers for the LCD result formatter.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package lcd_fmt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONVERT,
      SEND_CMD,
      SEND_SIGN,
      SEND_DIG,
      DONE
   } state_t;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_ZERO  = 8'h30;

   localparam int CONV_CYCLES = 16;
   localparam int NUM_DIGITS  = 5;

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   function automatic logic [19:0] dd_adjust(input logic [19:0] bcd);
      logic [19:0] r;
      r = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Magnitude of a two's-complement word; 16'h8000 maps to 16'h8000 (32768).
   function automatic logic [15:0] abs16(input logic [15:0] v);
      return v[15] ? (~v + 16'd1) : v;
   endfunction

endpackage

// File: rtl/lcd_result_formatter_if.sv
// Request/stream bundle between the ALU side, the formatter and the LCD driver.
// Latency: n/a (wires only).
// Backpressure: out_ready from the driver stalls the byte stream.
// master = ALU/driver side, slave = formatter.
interface lcd_result_formatter_if;
   logic        start;
   logic [15:0] value;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_is_cmd;
   logic        out_ready;
   logic        busy;
   logic        done;

   modport master (
      output start, value, out_ready,
      input  out_data, out_valid, out_is_cmd, busy, done
   );

   modport slave (
      input  start, value, out_ready,
      output out_data, out_valid, out_is_cmd, busy, done
   );
endinterface

// File: rtl/lcd_result_formatter_bin2bcd.sv
// Serial 16-bit binary to 5-digit BCD converter (double dabble, one bit per cycle).
// Latency: bcd_done pulses 16 cycles after the load edge; bcd then holds until the next load.
// Backpressure: none; load restarts the conversion unconditionally.
// Ports: clk, reset (async active-low), load, bin[15:0] in; bcd[19:0], bcd_done out.
module bin2bcd16_serial
   import lcd_fmt_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] bin,
   output logic [19:0] bcd,
   output logic        bcd_done
);

   logic [15:0] sr;
   logic [4:0]  cnt;
   logic        active;
   logic [19:0] adj;
   logic [35:0] shifted;

   assign adj     = dd_adjust(bcd);
   assign shifted = {adj, sr} << 1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr       <= '0;
         bcd      <= '0;
         cnt      <= '0;
         active   <= 1'b0;
         bcd_done <= 1'b0;
      end else begin
         bcd_done <= 1'b0;
         if (load) begin
            sr     <= bin;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b1;
         end else if (active) begin
            bcd <= shifted[35:16];
            sr  <= shifted[15:0];
            cnt <= cnt + 5'd1;
            if (cnt == 5'(CONV_CYCLES - 1)) begin
               active   <= 1'b0;
               bcd_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/lcd_result_formatter.sv
// Formats a signed 16-bit result as a 7-byte LCD stream: address cmd, sign, 5 digits.
// Latency: first byte valid 17 cycles after start is sampled; done 24 cycles after with no stalls.
// Backpressure: each byte is held (data, is_cmd, valid) until a valid&ready transfer.
// Ports: clk, reset (async active-low), bus (slave modport: start/value in,
//        out_data/out_valid/out_is_cmd out, out_ready in, busy/done out).
module lcd_result_formatter
   import lcd_fmt_pkg::*;
#(
   parameter logic [7:0] LINE_ADDR   = 8'hC0,
   parameter bit         BLANK_ZEROS = 1'b1
)
(
   input  logic                   clk,
   input  logic                   reset,
   lcd_result_formatter_if.slave  bus
);

   state_t      state;
   logic        neg;
   logic        lead;       // still inside the run of leading zero digits
   logic [2:0]  byte_cnt;   // index of the byte currently presented (0..6)

   logic        load;
   logic [15:0] mag;
   logic [19:0] bcd;
   logic        bcd_done;

   logic [2:0]  nxt_byte;
   logic [2:0]  nxt_idx;
   logic [3:0]  nxt_digit;
   logic        nxt_last;
   logic        nxt_blank;
   logic [7:0]  nxt_char;

   assign load = (state == IDLE) && bus.start;
   assign mag  = abs16(bus.value);

   bin2bcd16_serial u_bcd (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .bin      (mag),
      .bcd      (bcd),
      .bcd_done (bcd_done)
   );

   // Character for the byte that follows the current one. Byte 2 carries d4,
   // byte 6 carries d0, so the digit index is 6 - byte.
   always_comb begin
      nxt_byte = byte_cnt + 3'd1;
      nxt_idx  = 3'd6 - nxt_byte;
      case (nxt_idx)
         3'd0:    nxt_digit = bcd[3:0];
         3'd1:    nxt_digit = bcd[7:4];
         3'd2:    nxt_digit = bcd[11:8];
         3'd3:    nxt_digit = bcd[15:12];
         3'd4:    nxt_digit = bcd[19:16];
         default: nxt_digit = 4'h0;
      endcase
      nxt_last  = (nxt_idx == 3'd0);
      // d0 is never blanked so that a zero result still shows "0".
      nxt_blank = BLANK_ZEROS && lead && (nxt_digit == 4'h0) && !nxt_last;
      nxt_char  = nxt_blank ? CH_SPACE : (CH_ZERO + {4'h0, nxt_digit});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         neg            <= 1'b0;
         lead           <= 1'b0;
         byte_cnt       <= '0;
         bus.out_data   <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_is_cmd <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  neg      <= bus.value[15];
                  lead     <= 1'b1;
                  byte_cnt <= '0;
                  bus.busy <= 1'b1;
                  state    <= CONVERT;
               end
            end

            CONVERT: begin
               if (bcd_done) begin
                  bus.out_valid  <= 1'b1;
                  bus.out_is_cmd <= 1'b1;
                  bus.out_data   <= LINE_ADDR;
                  state          <= SEND_CMD;
               end
            end

            SEND_CMD: begin
               if (bus.out_ready) begin
                  byte_cnt       <= 3'd1;
                  bus.out_is_cmd <= 1'b0;
                  bus.out_data   <= neg ? CH_MINUS : CH_SPACE;
                  state          <= SEND_SIGN;
               end
            end

            SEND_SIGN: begin
               if (bus.out_ready) begin
                  byte_cnt     <= nxt_byte;
                  bus.out_data <= nxt_char;
                  lead         <= lead && (nxt_digit == 4'h0);
                  state        <= SEND_DIG;
               end
            end

            SEND_DIG: begin
               if (bus.out_ready) begin
                  if (byte_cnt == 3'd6) begin
                     byte_cnt      <= '0;
                     bus.out_valid <= 1'b0;
                     bus.out_data  <= '0;
                     bus.done      <= 1'b1;
                     state         <= DONE;
                  end else begin
                     byte_cnt     <= nxt_byte;
                     bus.out_data <= nxt_char;
                     lead         <= lead && (nxt_digit == 4'h0);
                  end
               end
            end

            DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_result_formatter.sv
// Scoreboard bench for lcd_result_formatter: directed values, backpressure, ignored starts, mid-stream reset.
// Two instances: leading-zero blanking on (dut0) and off (dut1).
module tb_lcd_result_formatter;

   typedef struct packed {
      logic       cmd;
      logic [7:0] dat;
   } byte_t;

   logic clk;
   logic reset;

   lcd_result_formatter_if if0();
   lcd_result_formatter_if if1();

   lcd_result_formatter #(.LINE_ADDR(8'hC0), .BLANK_ZEROS(1'b1)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   lcd_result_formatter #(.LINE_ADDR(8'hC0), .BLANK_ZEROS(1'b0)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   byte_t q0[$];
   byte_t q1[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   logic       stall0 = 1'b0;
   logic [8:0] hold0  = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for dut0: pops the scoreboard on every transfer, and checks that a
   // stalled byte is still presented unchanged one cycle later.
   always @(negedge clk) begin
      if (!reset) begin
         stall0 = 1'b0;
      end else begin
         if (stall0)
            check("stall_hold", 32'({if0.out_valid, if0.out_is_cmd, if0.out_data}), 32'({1'b1, hold0}));
         if (if0.out_valid && if0.out_ready) begin
            if (q0.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_byte0: got 0x%0h, expected no byte at %0t", if0.out_data, $time);
            end else begin
               byte_t e;
               e = q0.pop_front();
               check("byte0", 32'({if0.out_is_cmd, if0.out_data}), 32'(e));
            end
         end
         stall0 = if0.out_valid && !if0.out_ready;
         hold0  = {if0.out_is_cmd, if0.out_data};
      end
   end

   always @(negedge clk) begin
      if (reset && if1.out_valid && if1.out_ready) begin
         if (q1.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_byte1: got 0x%0h, expected no byte at %0t", if1.out_data, $time);
         end else begin
            byte_t e;
            e = q1.pop_front();
            check("byte1", 32'({if1.out_is_cmd, if1.out_data}), 32'(e));
         end
      end
   end

   // chars holds sign + d4..d0, first byte in the top 8 bits.
   task automatic push_stream(input int which, input logic [47:0] chars);
      byte_t b;
      b.cmd = 1'b1;
      b.dat = 8'hC0;
      if (which == 0) q0.push_back(b); else q1.push_back(b);
      for (int i = 0; i < 6; i++) begin
         b.cmd = 1'b0;
         b.dat = chars[47-8*i -: 8];
         if (which == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   // Called and returns #1 after a rising edge.
   task automatic run_one(input logic [15:0] v, input logic [47:0] chars, input bit inject,
                          input bit stall39, input int exp_done);
      int first_valid = 0;
      int done_k      = 0;
      int dones       = 0;
      int busy_bad    = 0;
      int stall_left  = 0;
      bit stalled     = 1'b0;
      push_stream(0, chars);
      if0.value = v;
      if0.start = 1'b1;
      @(posedge clk);            // edge N
      #1;
      if0.start = 1'b0;
      if0.value = 16'd77;        // must not affect the stream
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk);
         #1;
         if (inject && (k == 5 || k == 21 || k == 24)) begin
            if0.start = 1'b1;
            if0.value = 16'd99;
         end else begin
            if0.start = 1'b0;
         end
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) if0.out_ready = 1'b1;
         end else if (stall39 && !stalled && if0.out_valid && if0.out_data == 8'h39) begin
            if0.out_ready = 1'b0;
            stall_left    = 3;
            stalled       = 1'b1;
         end
         if (first_valid == 0 && if0.out_valid) first_valid = k;
         if (dones == 0 && !if0.busy) busy_bad++;
         if (if0.done) begin
            dones++;
            if (done_k == 0) done_k = k;
         end
         if (done_k > 0 && k == done_k + 3) break;
      end
      if0.start = 1'b0;
      check("first_valid_cycle", 32'(first_valid), 32'd17);
      check("done_cycle", 32'(done_k), 32'(exp_done));
      check("done_count", 32'(dones), 32'd1);
      check("busy_while_active", 32'(busy_bad), 32'd0);
      check("busy_idle_after", 32'(if0.busy), 32'd0);
      check("queue0_drained", 32'(q0.size()), 32'd0);
   endtask

   task automatic run_nb(input logic [15:0] v, input logic [47:0] chars);
      int done_k = 0;
      push_stream(1, chars);
      if1.value = v;
      if1.start = 1'b1;
      @(posedge clk);
      #1;
      if1.start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         #1;
         if (if1.done && done_k == 0) done_k = k;
         if (done_k > 0 && k == done_k + 2) break;
      end
      check("nb_done_cycle", 32'(done_k), 32'd24);
      check("queue1_drained", 32'(q1.size()), 32'd0);
   endtask

   initial begin
      reset         = 1'b1;
      if0.start     = 1'b0;
      if0.value     = '0;
      if0.out_ready = 1'b1;
      if1.start     = 1'b0;
      if1.value     = '0;
      if1.out_ready = 1'b1;

      #2 reset = 1'b0;
      #1;
      check("rst_out_valid", 32'(if0.out_valid), 32'd0);
      check("rst_out_data", 32'(if0.out_data), 32'd0);
      check("rst_out_is_cmd", 32'(if0.out_is_cmd), 32'd0);
      check("rst_busy", 32'(if0.busy), 32'd0);
      check("rst_done", 32'(if0.done), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      run_one(16'd1234,  48'h20_20_31_32_33_34, 1'b0, 1'b0, 24);
      run_one(16'h8000,  48'h2D_33_32_37_36_38, 1'b0, 1'b0, 24);
      run_one(16'd0,     48'h20_20_20_20_20_30, 1'b0, 1'b0, 24);
      run_one(-16'sd7,   48'h2D_20_20_20_20_37, 1'b0, 1'b0, 24);
      run_one(16'd100,   48'h20_20_20_31_30_30, 1'b0, 1'b0, 24);
      run_one(16'hFFFF,  48'h2D_20_20_20_20_31, 1'b0, 1'b0, 24);
      run_one(16'd32767, 48'h20_33_32_37_36_37, 1'b0, 1'b0, 24);

      run_nb(16'd0,      48'h20_30_30_30_30_30);
      run_nb(16'hFF85,   48'h2D_30_30_31_32_33);   // -123

      run_one(16'd905,   48'h20_20_20_39_30_35, 1'b0, 1'b1, 27);
      run_one(16'd4321,  48'h20_20_34_33_32_31, 1'b1, 1'b0, 24);

      // Reset in the middle of the digit phase.
      push_stream(0, 48'h20_31_32_33_34_35);
      if0.value = 16'd12345;
      if0.start = 1'b1;
      @(posedge clk);
      #1 if0.start = 1'b0;
      repeat (21) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_out_valid", 32'(if0.out_valid), 32'd0);
      check("midrst_out_data", 32'(if0.out_data), 32'd0);
      check("midrst_out_is_cmd", 32'(if0.out_is_cmd), 32'd0);
      check("midrst_busy", 32'(if0.busy), 32'd0);
      check("midrst_done", 32'(if0.done), 32'd0);
      q0.delete();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("no_resume_valid", 32'(if0.out_valid), 32'd0);
      run_one(16'd5, 48'h20_20_20_20_20_35, 1'b0, 1'b0, 24);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
